// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared opcodes, T-state encodings and control-word type for the SAP-1 sequencer
package control_sequencer_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef logic [5:0] tstate_t;

    localparam tstate_t T1 = 6'b000001;
    localparam tstate_t T2 = 6'b000010;
    localparam tstate_t T3 = 6'b000100;
    localparam tstate_t T4 = 6'b001000;
    localparam tstate_t T5 = 6'b010000;
    localparam tstate_t T6 = 6'b100000;

    // Field order Cp Ep Lm' CE' Li' Ei' La' Ea Su Eu Lb' Lo'; _n marks active-low lines.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_n;
        logic ce_n;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic su;
        logic eu;
        logic lb_n;
        logic lo_n;
    } ctrl_word_t;

    localparam ctrl_word_t CW_NOP = 12'b0011_1110_0011;

    function automatic logic is_onehot6(input tstate_t s);
        return (s != 6'd0) && ((s & (s - 6'd1)) == 6'd0);
    endfunction

    function automatic logic is_defined_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/control_ring_counter.sv
// rtl/control_ring_counter.sv - falling-edge six-state one-hot T-state ring with freeze and early wrap
module control_ring_counter
    import control_sequencer_pkg::*;
(
    input  logic    clk_i,
    input  logic    clr_i,
    input  logic    freeze_i,
    input  logic    wrap_i,
    output tstate_t state_o
);

    tstate_t state_q;
    tstate_t state_d;

    // Legality is checked before freeze so a corrupted ring always recovers.
    always_comb begin
        state_d = state_q;
        if (!is_onehot6(state_q)) begin
            state_d = T1;
        end else if (freeze_i) begin
            state_d = state_q;
        end else if (wrap_i || (state_q == T6)) begin
            state_d = T1;
        end else begin
            state_d = state_q << 1;
        end
    end

    always_ff @(negedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - SAP-1 controller-sequencer top: T-state ring plus opcode decode matrix
// Optional: CONTROL_SEQUENCER_EARLY_RETIRE_EN returns the ring to T1 after the last useful state.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] op_code,
    output logic       inc,
    output logic       pc_out_en,
    output logic       low_ld_mar,
    output logic       low_mem_out_en,
    output logic       low_ld_ir,
    output logic       low_ir_out_en,
    output logic       low_ld_acc,
    output logic       acc_out_en,
    output logic       sub_add,
    output logic       subadd_out_en,
    output logic       low_ld_b_reg,
    output logic       low_ld_out_reg,
    output logic       low_halt
);

    tstate_t    state;
    logic       halted_q;
    logic       halted_d;
    logic       halt_req;
    logic       freeze;
    logic       wrap;
    logic       is_arith;
    ctrl_word_t cw;
    logic       halt_n;

    assign halt_req = (state == T4) && (op_code == OP_HLT) && !halted_q;
    assign freeze   = halted_q || halt_req;
    assign halted_d = halted_q || halt_req;
    assign is_arith = (op_code == OP_ADD) || (op_code == OP_SUB);

`ifdef CONTROL_SEQUENCER_EARLY_RETIRE_EN
    assign wrap = ((state == T3) && !is_defined_op(op_code)) ||
                  ((state == T4) && (op_code == OP_OUT)) ||
                  ((state == T5) && (op_code == OP_LDA));
`else
    assign wrap = 1'b0;
`endif

    control_ring_counter u_ring (
        .clk_i    (clk),
        .clr_i    (clr),
        .freeze_i (freeze),
        .wrap_i   (wrap),
        .state_o  (state)
    );

    // Halt flag shares the ring's falling-edge timing so the freeze lands on the same edge.
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    always_comb begin
        cw     = CW_NOP;
        halt_n = 1'b1;
        if (clr) begin
            cw     = CW_NOP;
        end else if (halted_q) begin
            halt_n = 1'b0;
        end else begin
            case (state)
                T1: begin
                    cw.ep   = 1'b1;
                    cw.lm_n = 1'b0;
                end
                T2: begin
                    cw.cp   = 1'b1;
                end
                T3: begin
                    cw.ce_n = 1'b0;
                    cw.li_n = 1'b0;
                end
                T4: begin
                    cw.su = (op_code == OP_SUB);
                    if ((op_code == OP_LDA) || is_arith) begin
                        cw.ei_n = 1'b0;
                        cw.lm_n = 1'b0;
                    end else if (op_code == OP_OUT) begin
                        cw.ea   = 1'b1;
                        cw.lo_n = 1'b0;
                    end else if (op_code == OP_HLT) begin
                        halt_n  = 1'b0;
                    end
                end
                T5: begin
                    cw.su = (op_code == OP_SUB);
                    if (op_code == OP_LDA) begin
                        cw.ce_n = 1'b0;
                        cw.la_n = 1'b0;
                    end else if (is_arith) begin
                        cw.ce_n = 1'b0;
                        cw.lb_n = 1'b0;
                    end
                end
                T6: begin
                    cw.su = (op_code == OP_SUB);
                    if (is_arith) begin
                        cw.eu   = 1'b1;
                        cw.la_n = 1'b0;
                    end
                end
                default: begin
                    cw = CW_NOP;
                end
            endcase
        end
    end

    assign inc            = cw.cp;
    assign pc_out_en      = cw.ep;
    assign low_ld_mar     = cw.lm_n;
    assign low_mem_out_en = cw.ce_n;
    assign low_ld_ir      = cw.li_n;
    assign low_ir_out_en  = cw.ei_n;
    assign low_ld_acc     = cw.la_n;
    assign acc_out_en     = cw.ea;
    assign sub_add        = cw.su;
    assign subadd_out_en  = cw.eu;
    assign low_ld_b_reg   = cw.lb_n;
    assign low_ld_out_reg = cw.lo_n;
    assign low_halt       = halt_n;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer: directed table, reference model, corner sequences
module tb_control_sequencer;

    localparam logic [3:0] M_LDA = 4'b0000;
    localparam logic [3:0] M_ADD = 4'b0001;
    localparam logic [3:0] M_SUB = 4'b0010;
    localparam logic [3:0] M_OUT = 4'b1110;
    localparam logic [3:0] M_HLT = 4'b1111;

    // Observed word order: inc pc_out_en ld_mar mem_out ld_ir ir_out ld_acc acc_out sub_add subadd_out ld_b ld_out halt
    localparam logic [12:0] W_NOP  = 13'b0011111000111;
    localparam logic [12:0] W_T1   = 13'b0101111000111;
    localparam logic [12:0] W_T2   = 13'b1011111000111;
    localparam logic [12:0] W_T3   = 13'b0010011000111;
    localparam logic [12:0] W_LDA4 = 13'b0001101000111;
    localparam logic [12:0] W_LDA5 = 13'b0010110000111;
    localparam logic [12:0] W_ADD5 = 13'b0010111000011;
    localparam logic [12:0] W_ADD6 = 13'b0011110001111;
    localparam logic [12:0] W_SUB4 = 13'b0001101010111;
    localparam logic [12:0] W_SUB5 = 13'b0010111010011;
    localparam logic [12:0] W_SUB6 = 13'b0011110011111;
    localparam logic [12:0] W_OUT4 = 13'b0011111100101;
    localparam logic [12:0] W_HLT4 = 13'b0011111000110;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] op_code;
    logic inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir, low_ir_out_en;
    logic low_ld_acc, acc_out_en, sub_add, subadd_out_en, low_ld_b_reg, low_ld_out_reg, low_halt;
    logic [12:0] obs;

    int n_checks = 0;
    int n_fail   = 0;
    int t_m      = 1;
    bit h_m      = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [12:0] e4;
        logic [12:0] e5;
        logic [12:0] e6;
    } vec_t;

    vec_t vecs[7];

    control_sequencer dut (
        .clk            (clk),
        .clr            (clr),
        .op_code        (op_code),
        .inc            (inc),
        .pc_out_en      (pc_out_en),
        .low_ld_mar     (low_ld_mar),
        .low_mem_out_en (low_mem_out_en),
        .low_ld_ir      (low_ld_ir),
        .low_ir_out_en  (low_ir_out_en),
        .low_ld_acc     (low_ld_acc),
        .acc_out_en     (acc_out_en),
        .sub_add        (sub_add),
        .subadd_out_en  (subadd_out_en),
        .low_ld_b_reg   (low_ld_b_reg),
        .low_ld_out_reg (low_ld_out_reg),
        .low_halt       (low_halt)
    );

    always #5 clk = ~clk;

    assign obs = {inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir, low_ir_out_en,
                  low_ld_acc, acc_out_en, sub_add, subadd_out_en, low_ld_b_reg,
                  low_ld_out_reg, low_halt};

    function automatic logic [12:0] model_word(input int t, input logic [3:0] op, input bit halted);
        bit cp = 0, ep = 0, lm = 1, ce = 1, li = 1, ei = 1, la = 1;
        bit ea = 0, su = 0, eu = 0, lb = 1, lo = 1, hl = 1;
        bit arith;
        arith = (op == M_ADD) || (op == M_SUB);
        if (halted) begin
            hl = 0;
        end else if (t == 1) begin
            ep = 1; lm = 0;
        end else if (t == 2) begin
            cp = 1;
        end else if (t == 3) begin
            ce = 0; li = 0;
        end else begin
            if (op == M_SUB) su = 1;
            if (t == 4 && (op == M_LDA || arith)) begin ei = 0; lm = 0; end
            if (t == 4 && op == M_OUT) begin ea = 1; lo = 0; end
            if (t == 4 && op == M_HLT) hl = 0;
            if (t == 5 && op == M_LDA) begin ce = 0; la = 0; end
            if (t == 5 && arith) begin ce = 0; lb = 0; end
            if (t == 6 && arith) begin eu = 1; la = 0; end
        end
        return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hl};
    endfunction

    function automatic int last_state(input logic [3:0] op);
`ifdef CONTROL_SEQUENCER_EARLY_RETIRE_EN
        if (op == M_LDA) return 5;
        if (op == M_OUT) return 4;
        if (op == M_ADD || op == M_SUB || op == M_HLT) return 6;
        return 3;
`else
        return (op == 4'hF) ? 6 : 6;
`endif
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!h_m) begin
            if (t_m == 4 && op_code == M_HLT) h_m = 1'b1;
            else if (t_m == 6 || t_m == last_state(op_code)) t_m = 1;
            else t_m = t_m + 1;
        end
        #3;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        t_m = 1;
        h_m = 1'b0;
        #1 check("clr_nop", obs, W_NOP);
        #2 clr = 1'b0;
        #1 check("clr_release_t1", obs, W_T1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{M_LDA,   W_LDA4, W_LDA5, W_NOP};
        vecs[1] = '{M_ADD,   W_LDA4, W_ADD5, W_ADD6};
        vecs[2] = '{M_SUB,   W_SUB4, W_SUB5, W_SUB6};
        vecs[3] = '{M_OUT,   W_OUT4, W_NOP,  W_NOP};
        vecs[4] = '{4'b0101, W_NOP,  W_NOP,  W_NOP};
        vecs[5] = '{4'b0011, W_NOP,  W_NOP,  W_NOP};
        vecs[6] = '{4'b1101, W_NOP,  W_NOP,  W_NOP};

        clr = 1'b0;
        op_code = 4'b0000;
        #1 clr = 1'b1;
        #3 check("reset_nop", obs, W_NOP);
        #7 clr = 1'b0;
        #1 check("reset_release_t1", obs, W_T1);
        @(negedge clk);
        #3 check("fetch_t2", obs, W_T2);
        t_m = 2;
        tick();
        check("fetch_t3", obs, W_T3);
        tick();
        check("lda_t4_after_reset", obs, W_LDA4);
        tick();
        check("lda_t5_after_reset", obs, W_LDA5);
`ifndef CONTROL_SEQUENCER_EARLY_RETIRE_EN
        tick();
        check("lda_t6_after_reset", obs, W_NOP);
`endif
        tick();

`ifndef CONTROL_SEQUENCER_EARLY_RETIRE_EN
        for (int i = 0; i < 7; i++) begin
            check($sformatf("vec%0d_t1", i), obs, W_T1);
            op_code = 4'($urandom_range(0, 15));
            tick();
            check($sformatf("vec%0d_t2", i), obs, W_T2);
            tick();
            check($sformatf("vec%0d_t3", i), obs, W_T3);
            op_code = vecs[i].op;
            tick();
            check($sformatf("vec%0d_t4", i), obs, vecs[i].e4);
            tick();
            check($sformatf("vec%0d_t5", i), obs, vecs[i].e5);
            tick();
            check($sformatf("vec%0d_t6", i), obs, vecs[i].e6);
            tick();
        end
        check("wrap_to_t1", obs, W_T1);
`endif

        for (int i = 0; i < 200; i++) begin
            check("rand_model", obs, model_word(t_m, op_code, h_m));
            op_code = 4'($urandom_range(0, 14));
            tick();
        end

        for (int i = 0; i < 6 && t_m != 1; i++) begin
            op_code = M_ADD;
            tick();
        end
        check("hlt_t1", obs, W_T1);
        op_code = M_HLT;
        tick();
        check("hlt_t2", obs, W_T2);
        tick();
        check("hlt_t3", obs, W_T3);
        tick();
        check("hlt_t4", obs, W_HLT4);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("halted_frozen", obs, W_HLT4);
            if (i == 5) op_code = M_LDA;
        end
        do_clr();
        op_code = M_SUB;
        tick();
        check("post_hlt_t2", obs, W_T2);
        tick();
        check("post_hlt_t3", obs, W_T3);
        tick();
        check("sub_t4", obs, W_SUB4);
        tick();
        check("sub_t5", obs, W_SUB5);
        do_clr();
        tick();
        check("abort_then_t2", obs, W_T2);
        check("abort_model", obs, model_word(t_m, op_code, h_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Controller-sequencer of an 8-bit SAP-1 style accumulator CPU.
- A six-state ring counter (T1..T6) steps through fetch and execute.
- Outputs are decoded from the current T-state and the 4-bit op_code supplied by the instruction register.
- Drives all register-load, bus-enable, ALU and halt control lines, with the active-low naming shown in Ports.

Parameters:
- None. Opcode values are fixed constants defined in the shared package.

Ports:
- clk  input  1  system clock; the T-state advances on the falling edge
- clr  input  1  asynchronous, active-high reset
- op_code  input  4  instruction opcode from the IR upper nibble
- inc  output  1  PC increment (Cp), active high
- pc_out_en  output  1  PC drives bus (Ep), active high
- low_ld_mar  output  1  MAR load, active low
- low_mem_out_en  output  1  RAM drives bus, active low
- low_ld_ir  output  1  IR load, active low
- low_ir_out_en  output  1  IR address nibble drives bus, active low
- low_ld_acc  output  1  accumulator load, active low
- acc_out_en  output  1  accumulator drives bus, active high
- sub_add  output  1  ALU mode: 1 = subtract, 0 = add
- subadd_out_en  output  1  ALU drives bus, active high
- low_ld_b_reg  output  1  B register load, active low
- low_ld_out_reg  output  1  output register load, active low
- low_halt  output  1  halt, active low

Behaviour:
- Opcodes:
  - LDA = 0000
  - ADD = 0001
  - SUB = 0010
  - OUT = 1110
  - HLT = 1111
  - Any other value executes as NOP.
- NOP word: inc = 0, pc_out_en = 0, acc_out_en = 0, sub_add = 0, subadd_out_en = 0; every low_* output = 1.
- Every output not listed as asserted in a given state holds its NOP value.
- State: one-hot ring T1 to T2 to ... to T6 to T1, advancing on each falling clk edge.
- Register updates elsewhere occur on the rising edge, so the control word is stable mid-cycle.
- Outputs are purely combinational from the state, op_code and the halted flag.
- Reset (clr = 1, asynchronous):
  - State forced to T1 and halted flag cleared.
  - All outputs forced to the NOP word while clr is high, including low_halt = 1.
  - Once clr drops, the T1 word appears immediately.
  - clr asserted mid-instruction aborts the instruction; the sequencer restarts at T1.
- Fetch cycle (all opcodes):
  - T1: pc_out_en = 1, low_ld_mar = 0
  - T2: inc = 1
  - T3: low_mem_out_en = 0, low_ld_ir = 0
- LDA:
  - T4: low_ir_out_en = 0, low_ld_mar = 0
  - T5: low_mem_out_en = 0, low_ld_acc = 0
  - T6: NOP
- ADD:
  - T4: low_ir_out_en = 0, low_ld_mar = 0
  - T5: low_mem_out_en = 0, low_ld_b_reg = 0
  - T6: subadd_out_en = 1, low_ld_acc = 0, sub_add = 0
- SUB: same as ADD, except sub_add = 1 throughout T4..T6.
- OUT:
  - T4: acc_out_en = 1, low_ld_out_reg = 0
  - T5, T6: NOP
- HLT:
  - In T4, low_halt = 0 combinationally.
  - On the next falling edge the halted flag sets and the ring freezes at T4.
  - While halted: low_halt = 0, all other outputs NOP, op_code ignored.
  - Only clr exits the halted state.
- op_code is only decoded in T4..T6; it is don't-care during T1..T3.
- Exactly one T-state is active at all times. An illegal ring value (e.g. upset) recovers to T1 on the next edge.

Optional Feature:
- Macro CONTROL_SEQUENCER_EARLY_RETIRE_EN.
- When defined, the ring returns to T1 right after the last non-NOP state:
  - LDA: after T5
  - OUT: after T4
  - Undefined opcode: after T3
  - ADD, SUB: unchanged, six states
- When undefined, every instruction takes exactly 6 states. This is the baseline the test plan assumes.

Decomposition:
- Package control_sequencer_pkg holds:
  - opcode constants: OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT
  - T-state one-hot constants T1..T6
  - a 12-bit control-word typedef with field order Cp Ep Lm' CE' Li' Ei' La' Ea Su Eu Lb' Lo'
  - the NOP control-word constant
- One sub-module, control_ring_counter: falling-edge six-state one-hot ring with async clr, halt/freeze input and early-wrap input.
- The decode matrix lives in control_sequencer.

Test Plan:
- Pulse clr for 10 ns, op_code = 0000:
  - outputs equal the NOP word during clr;
  - then T1 gives pc_out_en = 1, low_ld_mar = 0;
  - T2 gives inc = 1;
  - T3 gives low_mem_out_en = 0, low_ld_ir = 0.
- LDA (0000) through T4..T6:
  - T4: low_ir_out_en = 0, low_ld_mar = 0
  - T5: low_mem_out_en = 0, low_ld_acc = 0
  - T6: NOP word
  - next falling edge returns to T1
- ADD (0001) vs SUB (0010):
  - T5: low_ld_b_reg = 0
  - T6: subadd_out_en = 1, low_ld_acc = 0
  - sub_add = 0 for ADD, 1 for SUB
- OUT (1110):
  - T4: acc_out_en = 1, low_ld_out_reg = 0
  - T5, T6: NOP
- HLT (1111):
  - T4: low_halt = 0
  - ring frozen for 10+ cycles with low_halt = 0 and other outputs NOP
  - changing op_code to 0000 has no effect
  - clr restores T1 with low_halt = 1
- Undefined opcode 0101 gives NOP in T4..T6. Asserting clr mid-T5 gives an immediate NOP word, then T1 after release.
